frame_reception: RTL and testbench
==================================

# frame_reception

Receive-side counterpart of the Ethernet MAC frame transmitter. It accepts the byte stream (`rx_in`/`rx_dv`) the transmitter emits and strips the preamble/SFD. It deserialises destination address, source address, EtherType and a fixed 4-byte payload, and checks the trailing CRC-32 FCS. It sits between the byte-wide PHY-side interface and the MAC client, presenting one decoded frame per `rx_done` pulse.

## Interface
- `PREAMBLE_MAX`, 7: maximum number of 0x55 preamble bytes accepted before SFD.
- `clk`  in  1  rising-edge clock, one byte per cycle when `rx_dv`=1.
- `rst`  in  1  synchronous, active-high reset.
- `rx_in`  in  8  received byte.
- `rx_dv`  in  1  byte valid; high for the whole frame, preamble through FCS.
- `dest_addr`  out  48  destination address of last good/bad completed frame.
- `src_addr`  out  48  source address.
- `eth_type`  out  16  EtherType.
- `data_out`  out  32  payload.
- `rx_done`  out  1  one-cycle pulse: frame complete, outputs above updated.
- `crc_ok`  out  1  FCS check result, valid from `rx_done`, held until next `rx_done`.
- `rx_error`  out  1  one-cycle pulse: frame aborted (bad SFD, preamble overrun, `rx_dv` dropped early).
- `state`  out  4  current FSM state (debug).
- `byte_count`  out  3  byte index within current field (debug).

## Operation
- Wire order: 0..7 × 0x55, 0xD5 (SFD), dest[47:40]..dest[7:0], src MSB-first, type MSB-first, data[31:24]..data[7:0], then FCS 4 bytes LSB-first.
- CRC-32: reflected poly 0xEDB88320, register init 0xFFFFFFFF, byte-wise LSB-first update over the 18 bytes dest..data. Expected FCS = ~register. `crc_ok`=1 iff the received FCS, assembled LSB-first, equals it.
- States (encoding): IDLE 0, PREAMBLE 1, DEST 2, SRC 3, TYPE 4, DATA 5, FCS 6, DONE 7, WAIT_IDLE 8.
- IDLE: on `rx_dv`=1: byte 0x55 → PREAMBLE (count 1); byte 0xD5 → DEST; other → `rx_error`, WAIT_IDLE.
- PREAMBLE: 0x55 → stay, count+1; count would exceed `PREAMBLE_MAX` → `rx_error`, WAIT_IDLE. 0xD5 → DEST, CRC register := 0xFFFFFFFF. Other → `rx_error`, WAIT_IDLE.
- DEST/SRC: 6 bytes each. TYPE: 2 bytes. DATA: 4 bytes. FCS: 4 bytes. `byte_count` runs 0..N-1 per field and resets to 0 on each field change.
- Fields shift into internal shadow registers. On FCS last byte → DONE.
- DONE (one cycle): copy shadows to outputs, set `crc_ok`, pulse `rx_done`. Then WAIT_IDLE if `rx_dv`=1, else IDLE.
- WAIT_IDLE: ignore bytes until `rx_dv`=0, then IDLE. Trailing bytes after FCS are not an error.
- `rx_dv`=0 in any of PREAMBLE..FCS: pulse `rx_error`, go IDLE. Outputs and `crc_ok` unchanged.
- Output registers change only in DONE; aborted frames never disturb them.

## Timing
- Reset values: all outputs 0; `state`=IDLE; `byte_count`=0; CRC register 0xFFFFFFFF.
- `rst` mid-frame: next cycle IDLE, all outputs 0, no `rx_done`/`rx_error` pulse.
- `rx_in` sampled only on edges where `rx_dv`=1.
- Latency: last FCS byte sampled at edge N; `rx_done`=1 and outputs valid during cycle after edge N+1 (DONE registered), i.e. one cycle after the FSM enters DONE.
- `rx_error` asserted the cycle after the offending edge, for one cycle.
- Back-to-back frames: `rx_dv` low for ≥1 cycle between frames is sufficient. A new frame starting the cycle after DONE (`rx_dv` already low) is accepted.

## Test plan
- Good frame: 7×0x55, 0xD5, dest 0x123456789ABC, src 0xABCDEF123456, type 0x0800, data 0x11223344, correct bench-computed FCS → one `rx_done`, fields match, `crc_ok`=1, no `rx_error`.
- Same frame with one FCS bit flipped → `rx_done`, fields match, `crc_ok`=0.
- No preamble, SFD first, then same frame → accepted identically, `crc_ok`=1.
- 8×0x55 then SFD → `rx_error` on the 8th 0x55, no `rx_done`, prior outputs retained.
- `rx_dv` dropped after 3 src bytes → `rx_error` pulse, IDLE; the following good frame (data 0xCAFEF00D) decodes with `crc_ok`=1.
- `rst` asserted during DATA → all outputs 0, `state`=0; a subsequent good frame decodes correctly.

Source files
------------

// File: rtl/frame_reception.sv
// Byte-wide Ethernet frame receiver: strips preamble/SFD, deserialises dest/src/type/4-byte payload, checks CRC-32 FCS.
// Results appear one cycle after the FSM enters DONE; there is no backpressure, one byte is consumed per rx_dv cycle.
module frame_reception #(
   parameter int PREAMBLE_MAX = 7
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  rx_in,
   input  logic        rx_dv,
   output logic [47:0] dest_addr,
   output logic [47:0] src_addr,
   output logic [15:0] eth_type,
   output logic [31:0] data_out,
   output logic        rx_done,
   output logic        crc_ok,
   output logic        rx_error,
   output logic [3:0]  state,
   output logic [2:0]  byte_count
);

   localparam int PW = $clog2(PREAMBLE_MAX + 1);

   typedef enum logic [3:0] {
      S_IDLE      = 4'd0,
      S_PREAMBLE  = 4'd1,
      S_DEST      = 4'd2,
      S_SRC       = 4'd3,
      S_TYPE      = 4'd4,
      S_DATA      = 4'd5,
      S_FCS       = 4'd6,
      S_DONE      = 4'd7,
      S_WAIT_IDLE = 4'd8
   } state_t;

   state_t          cur, nxt;
   logic [2:0]      cnt_nxt;
   logic [2:0]      field_last;
   logic [PW-1:0]   pre_cnt, pre_nxt;
   logic            err_nxt;
   logic            crc_init;
   logic [31:0]     crc;
   logic [47:0]     dest_sh, src_sh;
   logic [15:0]     type_sh;
   logic [31:0]     data_sh, fcs_sh;

   assign state = cur;

   function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c ^ {24'h0, d};
      for (int i = 0; i < 8; i++)
         r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
      return r;
   endfunction

   always_comb begin
      field_last = 3'd0;
      case (cur)
         S_DEST, S_SRC:  field_last = 3'd5;
         S_TYPE:         field_last = 3'd1;
         S_DATA, S_FCS:  field_last = 3'd3;
         default:        field_last = 3'd0;
      endcase
   end

   always_comb begin
      nxt      = cur;
      cnt_nxt  = 3'd0;
      pre_nxt  = pre_cnt;
      err_nxt  = 1'b0;
      crc_init = 1'b0;
      case (cur)
         S_IDLE: begin
            if (rx_dv) begin
               if (rx_in == 8'h55) begin
                  nxt     = S_PREAMBLE;
                  pre_nxt = PW'(1);
               end else if (rx_in == 8'hD5) begin
                  nxt      = S_DEST;
                  crc_init = 1'b1;
               end else begin
                  nxt     = S_WAIT_IDLE;
                  err_nxt = 1'b1;
               end
            end
         end
         S_PREAMBLE: begin
            if (!rx_dv) begin
               nxt     = S_IDLE;
               err_nxt = 1'b1;
            end else if (rx_in == 8'h55) begin
               if (pre_cnt == PW'(PREAMBLE_MAX)) begin
                  nxt     = S_WAIT_IDLE;
                  err_nxt = 1'b1;
               end else begin
                  pre_nxt = pre_cnt + 1'b1;
               end
            end else if (rx_in == 8'hD5) begin
               nxt      = S_DEST;
               crc_init = 1'b1;
            end else begin
               nxt     = S_WAIT_IDLE;
               err_nxt = 1'b1;
            end
         end
         S_DEST, S_SRC, S_TYPE, S_DATA, S_FCS: begin
            if (!rx_dv) begin
               nxt     = S_IDLE;
               err_nxt = 1'b1;
            end else if (byte_count == field_last) begin
               case (cur)
                  S_DEST:  nxt = S_SRC;
                  S_SRC:   nxt = S_TYPE;
                  S_TYPE:  nxt = S_DATA;
                  S_DATA:  nxt = S_FCS;
                  default: nxt = S_DONE;
               endcase
            end else begin
               cnt_nxt = byte_count + 3'd1;
            end
         end
         S_DONE:      nxt = rx_dv ? S_WAIT_IDLE : S_IDLE;
         S_WAIT_IDLE: if (!rx_dv) nxt = S_IDLE;
         default:     nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cur        <= S_IDLE;
         byte_count <= 3'd0;
         pre_cnt    <= '0;
         crc        <= 32'hFFFFFFFF;
         dest_sh    <= 48'h0;
         src_sh     <= 48'h0;
         type_sh    <= 16'h0;
         data_sh    <= 32'h0;
         fcs_sh     <= 32'h0;
         dest_addr  <= 48'h0;
         src_addr   <= 48'h0;
         eth_type   <= 16'h0;
         data_out   <= 32'h0;
         rx_done    <= 1'b0;
         crc_ok     <= 1'b0;
         rx_error   <= 1'b0;
      end else begin
         cur        <= nxt;
         byte_count <= cnt_nxt;
         pre_cnt    <= pre_nxt;
         rx_error   <= err_nxt;
         rx_done    <= 1'b0;
         if (crc_init)
            crc <= 32'hFFFFFFFF;
         if (rx_dv) begin
            case (cur)
               S_DEST: begin
                  dest_sh <= {dest_sh[39:0], rx_in};
                  crc     <= crc_byte(crc, rx_in);
               end
               S_SRC: begin
                  src_sh <= {src_sh[39:0], rx_in};
                  crc    <= crc_byte(crc, rx_in);
               end
               S_TYPE: begin
                  type_sh <= {type_sh[7:0], rx_in};
                  crc     <= crc_byte(crc, rx_in);
               end
               S_DATA: begin
                  data_sh <= {data_sh[23:0], rx_in};
                  crc     <= crc_byte(crc, rx_in);
               end
               S_FCS:   fcs_sh <= {rx_in, fcs_sh[31:8]};  // FCS arrives LSB-first
               default: ;
            endcase
         end
         // Visible outputs only move here, so aborted frames leave them intact.
         if (cur == S_DONE) begin
            dest_addr <= dest_sh;
            src_addr  <= src_sh;
            eth_type  <= type_sh;
            data_out  <= data_sh;
            crc_ok    <= (fcs_sh == ~crc);
            rx_done   <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_frame_reception.sv
// Directed bench for frame_reception: builds frames with a reference CRC-32 and checks decode, errors and reset.
module tb_frame_reception;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  rx_in;
   logic        rx_dv;
   logic [47:0] dest_addr, src_addr;
   logic [15:0] eth_type;
   logic [31:0] data_out;
   logic        rx_done, crc_ok, rx_error;
   logic [3:0]  state;
   logic [2:0]  byte_count;

   int n_cmp = 0;
   int n_err = 0;
   int done_cnt = 0;
   int err_cnt = 0;
   int d0, e0;

   logic [7:0] fb[$];

   localparam logic [47:0] D1 = 48'h123456789ABC;
   localparam logic [47:0] S1 = 48'hABCDEF123456;
   localparam logic [15:0] T1 = 16'h0800;
   localparam logic [31:0] P1 = 32'h11223344;

   frame_reception #(.PREAMBLE_MAX(7)) dut (
      .clk        (clk),
      .rst        (rst),
      .rx_in      (rx_in),
      .rx_dv      (rx_dv),
      .dest_addr  (dest_addr),
      .src_addr   (src_addr),
      .eth_type   (eth_type),
      .data_out   (data_out),
      .rx_done    (rx_done),
      .crc_ok     (crc_ok),
      .rx_error   (rx_error),
      .state      (state),
      .byte_count (byte_count)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rx_done)  done_cnt++;
      if (rx_error) err_cnt++;
   end

   function automatic logic [31:0] ref_crc(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c;
      for (int k = 0; k < 8; k++) begin
         if ((r[0] ^ d[k]) == 1'b1) r = (r >> 1) ^ 32'hEDB88320;
         else                       r = r >> 1;
      end
      return r;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic build(input int npre, input logic [47:0] d, input logic [47:0] s,
                        input logic [15:0] t, input logic [31:0] p, input logic [31:0] flip);
      logic [143:0] body;
      logic [31:0]  c;
      logic [7:0]   b;
      fb.delete();
      for (int i = 0; i < npre; i++) fb.push_back(8'h55);
      fb.push_back(8'hD5);
      body = {d, s, t, p};
      c = 32'hFFFFFFFF;
      for (int i = 0; i < 18; i++) begin
         b = body[143 - 8*i -: 8];
         fb.push_back(b);
         c = ref_crc(c, b);
      end
      c = ~c ^ flip;
      for (int i = 0; i < 4; i++) fb.push_back(c[8*i +: 8]);
   endtask

   task automatic send(input int lo, input int hi);
      for (int i = lo; i < hi; i++) begin
         rx_dv = 1'b1;
         rx_in = fb[i];
         tick();
      end
   endtask

   task automatic check_fields(input string tag, input logic [31:0] p);
      chk({tag, "_dest"}, {16'h0, dest_addr}, {16'h0, D1});
      chk({tag, "_src"},  {16'h0, src_addr},  {16'h0, S1});
      chk({tag, "_type"}, {48'h0, eth_type},  {48'h0, T1});
      chk({tag, "_data"}, {32'h0, data_out},  {32'h0, p});
   endtask

   initial begin
      logic [31:0] kc;
      logic [71:0] kat;
      rst = 1'b1; rx_dv = 1'b0; rx_in = 8'h00;
      repeat (3) tick();
      rst = 1'b0;
      tick();

      kat = 72'h313233343536373839;
      kc = 32'hFFFFFFFF;
      for (int i = 0; i < 9; i++) kc = ref_crc(kc, kat[71 - 8*i -: 8]);
      chk("ref_crc_check", {32'h0, ~kc}, 64'hCBF43926);

      chk("rst_state", {60'h0, state}, 64'd0);
      chk("rst_bcnt",  {61'h0, byte_count}, 64'd0);
      chk("rst_dest",  {16'h0, dest_addr}, 64'd0);
      chk("rst_data",  {32'h0, data_out}, 64'd0);
      chk("rst_flags", {61'h0, rx_done, crc_ok, rx_error}, 64'd0);

      // Good frame with full preamble
      build(7, D1, S1, T1, P1, 32'h0);
      send(0, 8);
      chk("t1_in_dest", {60'h0, state}, 64'd2);
      chk("t1_bcnt0", {61'h0, byte_count}, 64'd0);
      send(8, 11);
      chk("t1_bcnt3", {61'h0, byte_count}, 64'd3);
      send(11, 30);
      chk("t1_at_done", {60'h0, state}, 64'd7);
      chk("t1_no_done_yet", {63'h0, rx_done}, 64'd0);
      rx_dv = 1'b0;
      tick();
      chk("t1_done", {63'h0, rx_done}, 64'd1);
      chk("t1_idle", {60'h0, state}, 64'd0);
      chk("t1_crc_ok", {63'h0, crc_ok}, 64'd1);
      check_fields("t1", P1);
      tick();
      chk("t1_done_pulse", {63'h0, rx_done}, 64'd0);
      chk("t1_no_err", err_cnt, 64'd0);
      chk("t1_done_cnt", done_cnt, 64'd1);

      // FCS with one bit flipped
      build(7, D1, S1, T1, P1, 32'h0000_0100);
      send(0, 30);
      rx_dv = 1'b0;
      tick(); tick();
      chk("t2_done_cnt", done_cnt, 64'd2);
      chk("t2_crc_bad", {63'h0, crc_ok}, 64'd0);
      check_fields("t2", P1);

      // No preamble, SFD first
      build(0, D1, S1, T1, P1, 32'h0);
      send(0, 23);
      rx_dv = 1'b0;
      tick(); tick();
      chk("t3_done_cnt", done_cnt, 64'd3);
      chk("t3_crc_ok", {63'h0, crc_ok}, 64'd1);
      check_fields("t3", P1);

      // Preamble overrun: eight 0x55 bytes
      d0 = done_cnt; e0 = err_cnt;
      build(8, 48'hFFEEDDCCBBAA, S1, T1, 32'hDEADBEEF, 32'h0);
      send(0, 8);
      chk("t4_err_pulse", {63'h0, rx_error}, 64'd1);
      chk("t4_wait_idle", {60'h0, state}, 64'd8);
      send(8, 31);
      rx_dv = 1'b0;
      tick(); tick();
      chk("t4_err_cnt", err_cnt - e0, 64'd1);
      chk("t4_no_done", done_cnt - d0, 64'd0);
      chk("t4_crc_kept", {63'h0, crc_ok}, 64'd1);
      check_fields("t4", P1);

      // rx_dv dropped after 3 src bytes, then good frames back to back
      d0 = done_cnt; e0 = err_cnt;
      build(7, 48'h0102030405FF, S1, T1, P1, 32'h0);
      send(0, 17);
      rx_dv = 1'b0;
      tick();
      chk("t5_err_pulse", {63'h0, rx_error}, 64'd1);
      chk("t5_idle", {60'h0, state}, 64'd0);
      tick();
      chk("t5_err_once", {63'h0, rx_error}, 64'd0);
      chk("t5_dest_kept", {16'h0, dest_addr}, {16'h0, D1});
      build(7, D1, S1, T1, 32'hCAFEF00D, 32'h0);
      send(0, 30);
      rx_dv = 1'b0;
      tick();
      chk("t5_done", {63'h0, rx_done}, 64'd1);
      chk("t5_crc_ok", {63'h0, crc_ok}, 64'd1);
      check_fields("t5", 32'hCAFEF00D);
      build(0, D1, S1, T1, 32'h55AA55AA, 32'h0);
      send(0, 23);
      rx_dv = 1'b0;
      tick(); tick();
      chk("t5_b2b_data", {32'h0, data_out}, 64'h55AA55AA);
      chk("t5_b2b_crc", {63'h0, crc_ok}, 64'd1);
      chk("t5_done_cnt", done_cnt - d0, 64'd2);
      chk("t5_err_cnt", err_cnt - e0, 64'd1);

      // Reset in the middle of DATA
      d0 = done_cnt; e0 = err_cnt;
      build(7, D1, S1, T1, P1, 32'h0);
      send(0, 24);
      chk("t6_in_data", {60'h0, state}, 64'd5);
      chk("t6_bcnt2", {61'h0, byte_count}, 64'd2);
      rst = 1'b1;
      tick();
      chk("t6_state", {60'h0, state}, 64'd0);
      chk("t6_dest0", {16'h0, dest_addr}, 64'd0);
      chk("t6_src0", {16'h0, src_addr}, 64'd0);
      chk("t6_type_data0", {16'h0, eth_type, data_out}, 64'd0);
      chk("t6_flags0", {61'h0, rx_done, crc_ok, rx_error}, 64'd0);
      rst = 1'b0; rx_dv = 1'b0;
      tick();
      chk("t6_no_pulses", {32'h0, done_cnt - d0, err_cnt - e0}, 64'd0);
      send(0, 30);
      rx_dv = 1'b0;
      tick(); tick();
      chk("t6_crc_ok", {63'h0, crc_ok}, 64'd1);
      check_fields("t6", P1);
      chk("t6_done_cnt", done_cnt - d0, 64'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
